// File: rtl/reg_bank_pkg.sv
// reg_bank_pkg: shared definitions for the register bank.
//  - addr_width(): clog2-based address width (minimum 1 bit)
//  - FLAG_* : bit positions of the packed flag vector consumed by the
//             control unit's conditional-jump logic
package reg_bank_pkg;

  localparam int FLAG_ZERO  = 0;
  localparam int FLAG_SIGN  = 1;
  localparam int FLAG_CARRY = 2;
  localparam int NUM_FLAGS  = 3;

  // Number of bits needed to address n entries; never below 1.
  function automatic int addr_width(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) begin
      w = w + 1;
    end
    return w;
  endfunction

endpackage : reg_bank_pkg

// File: rtl/reg_bank_if.sv
// reg_bank_if: op / read / flag bundle of the register bank.
//  master (CPU control side) drives op_addr, load, inr, dcr, data_in,
//         rd_addr_a, rd_addr_b; receives rd_data_a/b and the flags.
//  slave  (reg_bank) is the mirror image.
interface reg_bank_if #(
  parameter int WIDTH  = 8,
  parameter int ADDR_W = 2
);

  logic [ADDR_W-1:0] op_addr;
  logic              load;
  logic              inr;
  logic              dcr;
  logic [WIDTH-1:0]  data_in;
  logic [ADDR_W-1:0] rd_addr_a;
  logic [WIDTH-1:0]  rd_data_a;
  logic [ADDR_W-1:0] rd_addr_b;
  logic [WIDTH-1:0]  rd_data_b;
  logic              flag_zero;
  logic              flag_sign;
  logic              flag_carry;

  modport master (
    output op_addr, load, inr, dcr, data_in, rd_addr_a, rd_addr_b,
    input  rd_data_a, rd_data_b, flag_zero, flag_sign, flag_carry
  );

  modport slave (
    input  op_addr, load, inr, dcr, data_in, rd_addr_a, rd_addr_b,
    output rd_data_a, rd_data_b, flag_zero, flag_sign, flag_carry
  );

endinterface : reg_bank_if

// File: rtl/reg_bank_cell.sv
// reg_bank_cell: one WIDTH-bit register with load / increment / decrement.
//  clk, rst  : rising-edge clock, synchronous active-low reset
//  en        : this cell is the target of the current op
//  load/inr/dcr : op strobes, priority load > inr > dcr
//  data_in   : load data
//  q         : stored value
//  wrap      : combinational; the op executing this cycle wraps
//              (SATURATE=0) or clamps (SATURATE=1)
module reg_bank_cell #(
  parameter int WIDTH    = 8,
  parameter int SATURATE = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic             inr,
  input  logic             dcr,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] q,
  output logic             wrap
);

  localparam logic [WIDTH:0] ONE = {{WIDTH{1'b0}}, 1'b1};

  logic [WIDTH:0]   inc;
  logic [WIDTH:0]   dec;
  logic [WIDTH-1:0] nxt;

  // One extra bit exposes carry-out (max+1) and borrow (0-1).
  assign inc = {1'b0, q} + ONE;
  assign dec = {1'b0, q} - ONE;

  // Next-value selection with op priority and wrap/clamp detection.
  always_comb begin
    nxt  = q;
    wrap = 1'b0;
    if (!en) begin
      nxt = q;
    end else if (load) begin
      nxt = data_in;
    end else if (inr) begin
      wrap = inc[WIDTH];
      nxt  = ((SATURATE != 0) && inc[WIDTH]) ? q : inc[WIDTH-1:0];
    end else if (dcr) begin
      wrap = dec[WIDTH];
      nxt  = ((SATURATE != 0) && dec[WIDTH]) ? q : dec[WIDTH-1:0];
    end else begin
      nxt = q;
    end
  end

  // Storage register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      q <= {WIDTH{1'b0}};
    end else begin
      q <= nxt;
    end
  end

endmodule : reg_bank_cell

// File: rtl/reg_bank.sv
// reg_bank: NUM_REGS x WIDTH register bank with per-register
// load/inr/dcr, two combinational read ports and zero/sign/carry flags.
//  clk  : rising-edge clock
//  rst  : synchronous active-low reset (clears registers and flags)
//  bus  : reg_bank_if slave modport (op strobes, read ports, flags)
module reg_bank
  import reg_bank_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int NUM_REGS = 4,
  parameter int SATURATE = 0
) (
  input  logic        clk,
  input  logic        rst,
  reg_bank_if.slave   bus
);

  localparam int ADDR_W = addr_width(NUM_REGS);
  localparam logic [ADDR_W:0] REG_COUNT = (ADDR_W + 1)'(NUM_REGS);

  logic [WIDTH-1:0]    q [NUM_REGS];
  logic [NUM_REGS-1:0] en;
  logic [NUM_REGS-1:0] wrap;
  logic [ADDR_W-1:0]   op_addr;
  logic [ADDR_W-1:0]   rd_addr_a;
  logic [ADDR_W-1:0]   rd_addr_b;
  logic                any_op;
  logic                exec;

  // Flag state: carry is stored directly; zero/sign are derived from the
  // register last written, which cannot change until the next executed op.
  logic                carry_q;
  logic                has_result;
  logic [ADDR_W-1:0]   last_addr;
  logic [WIDTH-1:0]    result;
  logic [NUM_FLAGS-1:0] flags;

  assign op_addr   = ADDR_W'(bus.op_addr);
  assign rd_addr_a = ADDR_W'(bus.rd_addr_a);
  assign rd_addr_b = ADDR_W'(bus.rd_addr_b);
  assign any_op    = bus.load | bus.inr | bus.dcr;
  // Out-of-range targets never execute, so flags hold for them.
  assign exec      = any_op && ({1'b0, op_addr} < REG_COUNT);

  // Per-cell enable decode.
  always_comb begin
    en = {NUM_REGS{1'b0}};
    for (int i = 0; i < NUM_REGS; i++) begin
      en[i] = exec && (op_addr == ADDR_W'(i));
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_cell
    reg_bank_cell #(
      .WIDTH    (WIDTH),
      .SATURATE (SATURATE)
    ) u_cell (
      .clk     (clk),
      .rst     (rst),
      .en      (en[g]),
      .load    (bus.load),
      .inr     (bus.inr),
      .dcr     (bus.dcr),
      .data_in (bus.data_in),
      .q       (q[g]),
      .wrap    (wrap[g])
    );
  end

  // Flag register: captures carry and the target of each executed op.
  always_ff @(posedge clk) begin
    if (!rst) begin
      carry_q    <= 1'b0;
      has_result <= 1'b0;
      last_addr  <= {ADDR_W{1'b0}};
    end else if (exec) begin
      // At most one cell is enabled, so OR-reduction picks its wrap.
      carry_q    <= |wrap;
      has_result <= 1'b1;
      last_addr  <= op_addr;
    end else begin
      carry_q    <= carry_q;
      has_result <= has_result;
      last_addr  <= last_addr;
    end
  end

  // Result mux and read-port muxes; unmatched addresses read as 0.
  always_comb begin
    result        = {WIDTH{1'b0}};
    bus.rd_data_a = {WIDTH{1'b0}};
    bus.rd_data_b = {WIDTH{1'b0}};
    for (int i = 0; i < NUM_REGS; i++) begin
      result        = result        | ((last_addr == ADDR_W'(i)) ? q[i] : {WIDTH{1'b0}});
      bus.rd_data_a = bus.rd_data_a | ((rd_addr_a == ADDR_W'(i)) ? q[i] : {WIDTH{1'b0}});
      bus.rd_data_b = bus.rd_data_b | ((rd_addr_b == ADDR_W'(i)) ? q[i] : {WIDTH{1'b0}});
    end
  end

  // Packed flag vector; all flags read 0 until the first op after reset.
  always_comb begin
    flags             = {NUM_FLAGS{1'b0}};
    flags[FLAG_ZERO]  = has_result && (result == {WIDTH{1'b0}});
    flags[FLAG_SIGN]  = has_result && result[WIDTH-1];
    flags[FLAG_CARRY] = carry_q;
  end

  assign bus.flag_zero  = flags[FLAG_ZERO];
  assign bus.flag_sign  = flags[FLAG_SIGN];
  assign bus.flag_carry = flags[FLAG_CARRY];

endmodule : reg_bank
